// File: rtl/dct_quant_if.sv
`default_nettype none
// ============================================================================
//  Module      : dct_quant_if
//  Description : Row bus between the 2-D DCT core and the quantizer stage.
//                Input side  : x_k_in (N x IW signed coefficients), in_valid,
//                              qshift (base quantizer shift).
//                Output side : q_out (N x OW signed levels), out_valid,
//                              out_row, out_first, out_last, blk_nz.
//                master = producer of rows / consumer of levels.
//                slave  = the quantizer unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dct_quant_if #(
    parameter int N  = 16,
    parameter int IW = 12,
    parameter int OW = 8,
    parameter int QW = 3
);
    logic [N*IW-1:0]            x_k_in;
    logic                       in_valid;
    logic [QW-1:0]              qshift;
    logic [N*OW-1:0]            q_out;
    logic                       out_valid;
    logic [$clog2(N)-1:0]       out_row;
    logic                       out_first;
    logic                       out_last;
    logic [$clog2(N*N+1)-1:0]   blk_nz;

    modport master (
        output x_k_in, in_valid, qshift,
        input  q_out, out_valid, out_row, out_first, out_last, blk_nz
    );

    modport slave (
        input  x_k_in, in_valid, qshift,
        output q_out, out_valid, out_row, out_first, out_last, blk_nz
    );
endinterface
`default_nettype wire

// File: rtl/dct_quant_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dct_quant_unit
//  Description : Zone-dependent shift quantizer for 16x16 2-D DCT blocks.
//                Takes one row of N signed IW-bit coefficients per in_valid
//                cycle, applies shift s = qshift_blk + zone(r+c) with
//                round-half-away-from-zero and saturation to +/-(2^(OW-1)-1),
//                and emits N signed OW-bit levels two cycles later.
//                Ports:
//                  clk  - clock, rising edge
//                  rstn - synchronous active-low reset
//                  bus  - dct_quant_if.slave (row in, levels/row tags out,
//                         block non-zero count on the last row)
//  Revision    : 1.0 - initial release
// ============================================================================
module dct_quant_unit #(
    parameter int N  = 16,
    parameter int IW = 12,
    parameter int OW = 8,
    parameter int QW = 3
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    dct_quant_if.slave   bus
);
    localparam int c_rw  = $clog2(N);          // row index width
    localparam int c_rsw = c_rw + 1;           // per-row non-zero count (0..N)
    localparam int c_nzw = $clog2(N*N + 1);    // per-block non-zero count
    localparam int c_sw  = QW + 1;             // total shift (base + zone 0..2)
    localparam int c_mw  = IW + 1;             // rounding headroom

    localparam logic [c_rw:0]   c_zone1_start = c_rsw'(4);
    localparam logic [c_rw:0]   c_zone2_start = c_rsw'(12);
    localparam logic [c_mw-1:0] c_lvl_max     = c_mw'((1 << (OW-1)) - 1);
    localparam logic [c_rw-1:0] c_last_row    = c_rw'(N - 1);

    // ---------------- input side / stage 1 ----------------
    logic [c_rw-1:0]            row_cnt_q,    row_cnt_d;
    logic [QW-1:0]              qshift_blk_q, qshift_blk_d;
    logic                       s1_valid_q,   s1_valid_d;
    logic [c_rw-1:0]            s1_row_q,     s1_row_d;
    logic [N-1:0]               s1_sign_q,    s1_sign_d;
    logic [N-1:0][IW-1:0]       s1_mag_q,     s1_mag_d;
    logic [N-1:0][c_sw-1:0]     s1_shift_q,   s1_shift_d;

    // ---------------- stage 2 / outputs ----------------
    logic [N*OW-1:0]            q_out_q,      q_out_d;
    logic                       out_valid_q,  out_valid_d;
    logic [c_rw-1:0]            out_row_q,    out_row_d;
    logic                       out_first_q,  out_first_d;
    logic                       out_last_q,   out_last_d;
    logic [c_nzw-1:0]           blk_nz_q,     blk_nz_d;
    logic [c_nzw-1:0]           nz_acc_q,     nz_acc_d;

    // combinational temporaries
    logic [QW-1:0]              w_shift_eff;
    logic [IW-1:0]              w_coef;
    logic [c_rw:0]              w_rc;
    logic [1:0]                 w_zone;
    logic [c_mw-1:0]            w_rnd;
    logic [c_mw-1:0]            w_m;
    logic [OW-2:0]              w_mag_sat;
    logic [OW-1:0]              w_lvl;
    logic [N*OW-1:0]            w_levels;
    logic [c_rsw-1:0]           w_row_sum;

    // Stage 1: row tracking, block shift latch, sign/magnitude and shift
    always_comb begin
        row_cnt_d    = row_cnt_q;
        qshift_blk_d = qshift_blk_q;
        s1_valid_d   = bus.in_valid;
        s1_row_d     = s1_row_q;
        s1_sign_d    = s1_sign_q;
        s1_mag_d     = s1_mag_q;
        s1_shift_d   = s1_shift_q;
        w_shift_eff  = qshift_blk_q;
        w_coef       = '0;
        w_rc         = '0;
        w_zone       = 2'd0;

        if (bus.in_valid) begin
            row_cnt_d = row_cnt_q + c_rw'(1);
            // Row 0 latches the block shift and already uses the new value.
            if (row_cnt_q == '0) begin
                qshift_blk_d = bus.qshift;
                w_shift_eff  = bus.qshift;
            end
            s1_row_d = row_cnt_q;
            for (int c = 0; c < N; c++) begin
                w_coef       = bus.x_k_in[c*IW +: IW];
                s1_sign_d[c] = w_coef[IW-1];
                // -2^(IW-1) maps to 2^(IW-1), which still fits IW unsigned bits.
                s1_mag_d[c]  = w_coef[IW-1] ? (~w_coef + IW'(1)) : w_coef;
                w_rc         = {1'b0, row_cnt_q} + c_rsw'(c);
                if (w_rc < c_zone1_start)
                    w_zone = 2'd0;
                else if (w_rc < c_zone2_start)
                    w_zone = 2'd1;
                else
                    w_zone = 2'd2;
                s1_shift_d[c] = c_sw'(w_shift_eff) + c_sw'(w_zone);
            end
        end
    end

    // Stage 2: round, shift, saturate, re-sign, count non-zero levels
    always_comb begin
        q_out_d     = q_out_q;
        out_valid_d = s1_valid_q;
        out_row_d   = out_row_q;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        blk_nz_d    = '0;
        nz_acc_d    = nz_acc_q;
        w_rnd       = '0;
        w_m         = '0;
        w_mag_sat   = '0;
        w_lvl       = '0;
        w_levels    = '0;
        w_row_sum   = '0;

        for (int c = 0; c < N; c++) begin
            w_rnd = (s1_shift_q[c] != '0) ? (c_mw'(1) << (s1_shift_q[c] - c_sw'(1))) : '0;
            w_m   = (c_mw'(s1_mag_q[c]) + w_rnd) >> s1_shift_q[c];
            w_mag_sat = (w_m > c_lvl_max) ? c_lvl_max[OW-2:0] : w_m[OW-2:0];
            // Negating a zero magnitude yields zero, so no -0 can appear.
            w_lvl = s1_sign_q[c] ? (-{1'b0, w_mag_sat}) : {1'b0, w_mag_sat};
            w_levels[c*OW +: OW] = w_lvl;
            if (w_mag_sat != '0)
                w_row_sum = w_row_sum + c_rsw'(1);
        end

        if (s1_valid_q) begin
            q_out_d     = w_levels;
            out_row_d   = s1_row_q;
            out_first_d = (s1_row_q == '0);
            out_last_d  = (s1_row_q == c_last_row);
            if (s1_row_q == '0)
                nz_acc_d = c_nzw'(w_row_sum);
            else
                nz_acc_d = nz_acc_q + c_nzw'(w_row_sum);
            if (s1_row_q == c_last_row)
                blk_nz_d = nz_acc_q + c_nzw'(w_row_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            row_cnt_q    <= '0;
            qshift_blk_q <= '0;
            s1_valid_q   <= 1'b0;
            s1_row_q     <= '0;
            s1_sign_q    <= '0;
            s1_mag_q     <= '0;
            s1_shift_q   <= '0;
            q_out_q      <= '0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            blk_nz_q     <= '0;
            nz_acc_q     <= '0;
        end else begin
            row_cnt_q    <= row_cnt_d;
            qshift_blk_q <= qshift_blk_d;
            s1_valid_q   <= s1_valid_d;
            s1_row_q     <= s1_row_d;
            s1_sign_q    <= s1_sign_d;
            s1_mag_q     <= s1_mag_d;
            s1_shift_q   <= s1_shift_d;
            q_out_q      <= q_out_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            blk_nz_q     <= blk_nz_d;
            nz_acc_q     <= nz_acc_d;
        end
    end

    assign bus.q_out     = q_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.blk_nz    = blk_nz_q;

endmodule
`default_nettype wire
